// File: rtl/inverse_transformer.sv
// inverse_transformer: recovers original matrix entries as (mod - trans) / scale, one entry at a time.
// Ports: clk, rst (async, active-high); start begins a run; scale_*/trans_* per-row
// parameters latched at start; rd_addr/rd_data combinational read of the modified matrix;
// wr_en/wr_addr/wr_data single-entry write of the recovered entry; busy/done run status;
// inexact/err_div0/err_neg sticky flags cleared by the next accepted start.
module inverse_transformer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] scale_x,
  input  logic [W-1:0] scale_y,
  input  logic [W-1:0] scale_z,
  input  logic [W-1:0] trans_x,
  input  logic [W-1:0] trans_y,
  input  logic [W-1:0] trans_z,
  output logic [3:0]   rd_addr,
  input  logic [W-1:0] rd_data,
  output logic         wr_en,
  output logic [3:0]   wr_addr,
  output logic [W-1:0] wr_data,
  output logic         busy,
  output logic         done,
  output logic         inexact,
  output logic         err_div0,
  output logic         err_neg
);
  localparam int CW = $clog2(W);
  typedef enum logic [2:0] {IDLE, FETCH, SUB, DIV, WRITE, DONE} state_t;
  state_t state, nextState;
  logic [W-1:0] sx, sy, sz, tx, ty, tz, curScale, curTrans, dvd, rem, lastData;
  logic [3:0] idx;
  logic [CW-1:0] cnt;
  logic [W:0] remShift;
  logic remGe;
  // dvd doubles as the quotient: quotient bits shift in at the LSB as the dividend shifts out.
  assign remShift = {rem, dvd[W-1]};
  assign remGe = remShift >= {1'b0, curScale};
  assign busy = !(state == IDLE || state == DONE);
  assign done = state == DONE;
  assign wr_en = state == WRITE;
  assign wr_addr = idx;
  assign wr_data = wr_en ? dvd : lastData;
  assign rd_addr = state == IDLE ? 4'd0 : idx;
  always_comb begin
    nextState = state;
    case (state)
      IDLE:  nextState = start ? FETCH : IDLE;
      FETCH: nextState = SUB;
      SUB:   nextState = (curScale == '0 || dvd < curTrans) ? WRITE : DIV;
      DIV:   nextState = cnt == '0 ? WRITE : DIV;
      WRITE: nextState = idx == 4'd8 ? DONE : FETCH;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nextState;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {sx, sy, sz, tx, ty, tz} <= '0;
      {curScale, curTrans, dvd, rem, lastData} <= '0;
      idx <= '0;
      cnt <= '0;
      {inexact, err_div0, err_neg} <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          {sx, sy, sz, tx, ty, tz} <= {scale_x, scale_y, scale_z, trans_x, trans_y, trans_z};
          {inexact, err_div0, err_neg} <= '0;
          idx <= '0;
        end
        FETCH: begin
          dvd <= rd_data;
          curScale <= idx < 4'd3 ? sx : idx < 4'd6 ? sy : sz;
          curTrans <= idx < 4'd3 ? tx : idx < 4'd6 ? ty : tz;
        end
        SUB: begin
          // rem is cleared on every path so a nonzero rem at WRITE always means an inexact division.
          rem <= '0;
          if (curScale == '0) begin
            dvd <= '1;
            err_div0 <= 1'b1;
          end else if (dvd < curTrans) begin
            dvd <= '0;
            err_neg <= 1'b1;
          end else begin
            dvd <= dvd - curTrans;
            cnt <= CW'(W - 1);
          end
        end
        DIV: begin
          rem <= remGe ? W'(remShift - {1'b0, curScale}) : remShift[W-1:0];
          dvd <= {dvd[W-2:0], remGe};
          cnt <= cnt - 1'b1;
        end
        WRITE: begin
          lastData <= dvd;
          if (rem != '0) inexact <= 1'b1;
          if (idx != 4'd8) idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule
